// File: rtl/uq_tdd_sw_ctrl_pkg.sv
// Shared types for the TDD RF front-end switch controller: state encoding,
// per-state output decode and guard-gap selection.
package uq_tdd_sw_ctrl_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int ERR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UL_ON   = 3'd1,
    ST_U2D_SW  = 3'd2,
    ST_U2D_PA  = 3'd3,
    ST_DL_ON   = 3'd4,
    ST_D2U_SW  = 3'd5,
    ST_D2U_LNA = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    GAP_UL2DL  = 2'd0,
    GAP_PA_ON  = 2'd1,
    GAP_DL2UL  = 2'd2,
    GAP_LNA_ON = 2'd3
  } gap_sel_e;

  typedef struct packed {
    logic pa_en;
    logic lna_en;
    logic sw_dl;
  } rf_ctl_t;

  function automatic rf_ctl_t rf_decode(input state_e st);
    rf_ctl_t c;
    c = '{pa_en: 1'b0, lna_en: 1'b0, sw_dl: 1'b0};
    case (st)
      ST_UL_ON:  c.lna_en = 1'b1;
      ST_U2D_PA: c.sw_dl  = 1'b1;
      ST_DL_ON:  begin c.pa_en = 1'b1; c.sw_dl = 1'b1; end
      ST_D2U_SW: c.sw_dl  = 1'b1;
      default:   c = '{pa_en: 1'b0, lna_en: 1'b0, sw_dl: 1'b0};
    endcase
    return c;
  endfunction

  // Untimed states map to an arbitrary gap; their done flag is ignored.
  function automatic gap_sel_e gap_select(input state_e st);
    gap_sel_e g;
    case (st)
      ST_U2D_SW:  g = GAP_UL2DL;
      ST_U2D_PA:  g = GAP_PA_ON;
      ST_D2U_SW:  g = GAP_DL2UL;
      ST_D2U_LNA: g = GAP_LNA_ON;
      default:    g = GAP_UL2DL;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/uq_tdd_sw_ctrl_gap_timer.sv
// Guard-gap timer: up-counter cleared on state entry, shadowed gap config
// captured at the start of each transition, done when the count hits the gap.
module uq_tdd_sw_ctrl_gap_timer
  import uq_tdd_sw_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] ul2dl_gap,
  input  logic [CNT_W-1:0] pa_on_dly,
  input  logic [CNT_W-1:0] dl2ul_gap,
  input  logic [CNT_W-1:0] lna_on_dly,
  input  gap_sel_e         sel,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sh_ul2dl;
  logic [CNT_W-1:0] sh_pa_on;
  logic [CNT_W-1:0] sh_dl2ul;
  logic [CNT_W-1:0] sh_lna_on;
  logic [CNT_W-1:0] gap_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sh_ul2dl  <= '0;
      sh_pa_on  <= '0;
      sh_dl2ul  <= '0;
      sh_lna_on <= '0;
    end else begin
      cnt <= clr ? '0 : cnt + CNT_W'(1);
      if (load) begin
        sh_ul2dl  <= ul2dl_gap;
        sh_pa_on  <= pa_on_dly;
        sh_dl2ul  <= dl2ul_gap;
        sh_lna_on <= lna_on_dly;
      end
    end
  end

  always_comb begin
    gap_cur = sh_ul2dl;
    case (sel)
      GAP_UL2DL:  gap_cur = sh_ul2dl;
      GAP_PA_ON:  gap_cur = sh_pa_on;
      GAP_DL2UL:  gap_cur = sh_dl2ul;
      GAP_LNA_ON: gap_cur = sh_lna_on;
      default:    gap_cur = sh_ul2dl;
    endcase
    done = (cnt == gap_cur);
  end

endmodule

// File: rtl/uq_tdd_sw_ctrl.sv
// Break-before-make PA/LNA/T-R switch sequencer driven by the TDD DL/UL decision.
//   state      | meaning
//   IDLE       | not valid / reset: everything off, switch on UL
//   UL_ON      | receive: LNA on, switch UL
//   U2D_SW     | LNA off, waiting ul2dl_gap before moving switch to DL
//   U2D_PA     | switch DL, waiting pa_on_dly before PA on
//   DL_ON      | transmit: PA on, switch DL
//   D2U_SW     | PA off, waiting dl2ul_gap before moving switch to UL
//   D2U_LNA    | switch UL, waiting lna_on_dly before LNA on
module uq_tdd_sw_ctrl
  import uq_tdd_sw_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             tdd_valid,
  input  logic             tdd_in,
  input  logic [CNT_W-1:0] ul2dl_gap,
  input  logic [CNT_W-1:0] pa_on_dly,
  input  logic [CNT_W-1:0] dl2ul_gap,
  input  logic [CNT_W-1:0] lna_on_dly,
  output logic             pa_en,
  output logic             lna_en,
  output logic             sw_dl,
  output logic [ERR_W-1:0] abort_cnt
);

  state_e  state;
  state_e  nxt;
  logic    tdd_q;
  logic    abort;
  logic    load;
  logic    entry;
  logic    gap_done;
  rf_ctl_t ctl_nxt;

  // Plain data register: keeps tracking tdd_in through reset so a restart
  // immediately honours the current direction.
  always_ff @(posedge clk) begin
    tdd_q <= tdd_in;
  end

  always_comb begin
    nxt   = state;
    abort = 1'b0;
    load  = 1'b0;
    if (!tdd_valid) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt  = tdd_q ? ST_U2D_SW : ST_D2U_LNA;
          load = 1'b1;
        end
        ST_UL_ON: begin
          if (tdd_q) begin
            nxt  = ST_U2D_SW;
            load = 1'b1;
          end
        end
        ST_U2D_SW: begin
          if (!tdd_q) begin
            nxt   = ST_D2U_LNA;
            abort = 1'b1;
            load  = 1'b1;
          end else if (gap_done) begin
            nxt = ST_U2D_PA;
          end
        end
        ST_U2D_PA: begin
          if (!tdd_q) begin
            nxt   = ST_D2U_SW;
            abort = 1'b1;
            load  = 1'b1;
          end else if (gap_done) begin
            nxt = ST_DL_ON;
          end
        end
        ST_DL_ON: begin
          if (!tdd_q) begin
            nxt  = ST_D2U_SW;
            load = 1'b1;
          end
        end
        ST_D2U_SW: begin
          if (tdd_q) begin
            nxt   = ST_U2D_PA;
            abort = 1'b1;
            load  = 1'b1;
          end else if (gap_done) begin
            nxt = ST_D2U_LNA;
          end
        end
        ST_D2U_LNA: begin
          if (tdd_q) begin
            nxt   = ST_U2D_SW;
            abort = 1'b1;
            load  = 1'b1;
          end else if (gap_done) begin
            nxt = ST_UL_ON;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
    entry   = (nxt != state) || !tdd_valid;
    ctl_nxt = rf_decode(nxt);
  end

  uq_tdd_sw_ctrl_gap_timer #(
    .CNT_W (CNT_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (i_rst),
    .clr        (entry),
    .load       (load),
    .ul2dl_gap  (ul2dl_gap),
    .pa_on_dly  (pa_on_dly),
    .dl2ul_gap  (dl2ul_gap),
    .lna_on_dly (lna_on_dly),
    .sel        (gap_select(state)),
    .done       (gap_done)
  );

  // Outputs decode the next state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      pa_en     <= 1'b0;
      lna_en    <= 1'b0;
      sw_dl     <= 1'b0;
      abort_cnt <= '0;
    end else begin
      state  <= nxt;
      pa_en  <= ctl_nxt.pa_en;
      lna_en <= ctl_nxt.lna_en;
      sw_dl  <= ctl_nxt.sw_dl;
      if (abort && (abort_cnt != {ERR_W{1'b1}})) begin
        abort_cnt <= abort_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uq_tdd_sw_ctrl.sv
// Bench for uq_tdd_sw_ctrl: rung/heading model checked every cycle plus
// hand-computed latency and abort expectations.
module tb_uq_tdd_sw_ctrl;

  logic        clk;
  logic        i_rst;
  logic        tdd_valid;
  logic        tdd_in;
  logic [11:0] ul2dl_gap, pa_on_dly, dl2ul_gap, lna_on_dly;
  logic        pa_en, lna_en, sw_dl;
  logic [15:0] abort_cnt;
  logic        s_pa_en, s_lna_en, s_sw_dl;
  logic [3:0]  s_abort_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uq_tdd_sw_ctrl dut (
    .clk(clk), .i_rst(i_rst), .tdd_valid(tdd_valid), .tdd_in(tdd_in),
    .ul2dl_gap(ul2dl_gap), .pa_on_dly(pa_on_dly), .dl2ul_gap(dl2ul_gap),
    .lna_on_dly(lna_on_dly), .pa_en(pa_en), .lna_en(lna_en), .sw_dl(sw_dl),
    .abort_cnt(abort_cnt)
  );

  uq_tdd_sw_ctrl #(.CNT_W(12), .ERR_W(4)) dut_sat (
    .clk(clk), .i_rst(i_rst), .tdd_valid(tdd_valid), .tdd_in(tdd_in),
    .ul2dl_gap(ul2dl_gap), .pa_on_dly(pa_on_dly), .dl2ul_gap(dl2ul_gap),
    .lna_on_dly(lna_on_dly), .pa_en(s_pa_en), .lna_en(s_lna_en), .sw_dl(s_sw_dl),
    .abort_cnt(s_abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the front end sits on a ladder of rungs
  //   0 = LNA on, 1 = quiet with switch UL, 2 = quiet with switch DL, 3 = PA on,
  // walking toward the heading given by the delayed direction. Each quiet rung is
  // held for (gap+1) cycles; a heading flip on a quiet rung restarts it and counts.
  int m_rung = 1, m_head = 0, m_t = 0, m_ab = 0;
  bit m_idle = 1'b1, m_tq = 1'b0;
  int s_u2d = 0, s_pa = 0, s_d2u = 0, s_lna = 0;

  function automatic int gap_now();
    if (m_rung == 1) return m_head ? s_u2d : s_lna;
    return m_head ? s_pa : s_d2u;
  endfunction

  task automatic snap();
    s_u2d = ul2dl_gap; s_pa = pa_on_dly; s_d2u = dl2ul_gap; s_lna = lna_on_dly;
    m_t = 0;
  endtask

  always @(posedge clk) begin
    if (i_rst) begin
      m_idle = 1'b1; m_ab = 0;
    end else if (!tdd_valid) begin
      m_idle = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0; m_rung = 1; m_head = m_tq; snap();
    end else if (m_rung == 0) begin
      if (m_tq) begin m_rung = 1; m_head = 1; snap(); end
    end else if (m_rung == 3) begin
      if (!m_tq) begin m_rung = 2; m_head = 0; snap(); end
    end else if (int'(m_tq) != m_head) begin
      m_head = m_tq; m_ab++; snap();
    end else if (m_t == gap_now()) begin
      m_rung = m_head ? m_rung + 1 : m_rung - 1; m_t = 0;
    end else begin
      m_t++;
    end
    m_tq = tdd_in;
  end

  bit p_pa = 0, p_lna = 0, p_sw = 0, p_idle = 1;

  always @(negedge clk) begin
    int e_pa, e_lna, e_sw, e_sat;
    e_pa  = (!m_idle && m_rung == 3);
    e_lna = (!m_idle && m_rung == 0);
    e_sw  = (!m_idle && m_rung >= 2);
    e_sat = (m_ab > 15) ? 15 : m_ab;
    chk("cyc_pa_en", pa_en, e_pa);
    chk("cyc_lna_en", lna_en, e_lna);
    chk("cyc_sw_dl", sw_dl, e_sw);
    chk("cyc_abort_cnt", abort_cnt, m_ab);
    chk("cyc_sat_abort_cnt", s_abort_cnt, e_sat);
    chk("inv_pa_and_lna", pa_en & lna_en, 0);
    if (sw_dl != p_sw && !m_idle && !p_idle)
      chk("inv_sw_moves_quiet", p_pa | p_lna | pa_en | lna_en, 0);
    p_pa = pa_en; p_lna = lna_en; p_sw = sw_dl; p_idle = m_idle;
  end

  // Ticks up to budget times; reports the offset of the first change of each output.
  task automatic measure(input int budget, input int poke_k, input logic [11:0] poke_val,
                         output int t_pa, output int t_lna, output int t_sw);
    logic pa0, lna0, sw0;
    pa0 = pa_en; lna0 = lna_en; sw0 = sw_dl;
    t_pa = -1; t_lna = -1; t_sw = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (k == poke_k) ul2dl_gap = poke_val;
      if (t_pa  < 0 && pa_en  != pa0)  t_pa  = k;
      if (t_lna < 0 && lna_en != lna0) t_lna = k;
      if (t_sw  < 0 && sw_dl  != sw0)  t_sw  = k;
    end
  endtask

  task automatic wait_lna(input logic v, input string nm);
    int k = 0;
    while (lna_en != v && k < 100) begin tick(); k++; end
    if (lna_en != v) chk({nm, "_timeout"}, lna_en, v);
  endtask

  task automatic wait_pa(input logic v, input string nm);
    int k = 0;
    while (pa_en != v && k < 100) begin tick(); k++; end
    if (pa_en != v) chk({nm, "_timeout"}, pa_en, v);
  endtask

  initial begin
    int t_pa, t_lna, t_sw, r, m, ab0, pa_hi, sw_fall;
    i_rst = 1; tdd_valid = 0; tdd_in = 0;
    ul2dl_gap = 3; pa_on_dly = 3; dl2ul_gap = 3; lna_on_dly = 3;
    repeat (3) tick();
    chk("rst_pa_en", pa_en, 0);
    chk("rst_lna_en", lna_en, 0);
    chk("rst_sw_dl", sw_dl, 0);
    chk("rst_abort_cnt", abort_cnt, 0);

    // Safe start toward UL: 4 quiet cycles then LNA on
    i_rst = 0; tdd_valid = 1;
    measure(10, -1, 0, t_pa, t_lna, t_sw);
    chk("start_lna_on_at", t_lna, 5);
    chk("start_pa_quiet", t_pa, -1);
    chk("start_sw_quiet", t_sw, -1);

    // UL->DL latency with ul2dl=5, pa_on=2
    ul2dl_gap = 5; pa_on_dly = 2;
    tdd_in = 1;
    measure(20, -1, 0, t_pa, t_lna, t_sw);
    chk("u2d_lna_off_at", t_lna, 2);
    chk("u2d_sw_dl_at", t_sw, 8);
    chk("u2d_pa_on_at", t_pa, 11);

    // DL->UL latency with dl2ul=3, lna_on=3
    tdd_in = 0;
    measure(20, -1, 0, t_pa, t_lna, t_sw);
    chk("d2u_pa_off_at", t_pa, 2);
    chk("d2u_sw_ul_at", t_sw, 6);
    chk("d2u_lna_on_at", t_lna, 10);

    // Abort out of U2D_PA
    pa_on_dly = 5;
    ab0 = abort_cnt;
    tdd_in = 1;
    r = 0;
    while (!sw_dl && r < 40) begin tick(); r++; end
    chk("abort_reach_sw_dl", sw_dl, 1);
    m = cyc; tdd_in = 0; pa_hi = 0; sw_fall = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pa_en) pa_hi++;
      if (sw_fall < 0 && !sw_dl) sw_fall = cyc - m;
    end
    chk("abort_pa_never_on", pa_hi, 0);
    chk("abort_sw_ul_at", sw_fall, 6);
    chk("abort_cnt_step", abort_cnt - ab0, 1);

    // Gap config changed mid-transition only applies to the next one
    wait_lna(1, "cfg_wait_ul");
    ul2dl_gap = 5; pa_on_dly = 2;
    tdd_in = 1;
    measure(20, 3, 12'd20, t_pa, t_lna, t_sw);
    chk("cfg_cur_sw_dl_at", t_sw, 8);
    wait_pa(1, "cfg_wait_dl");
    tdd_in = 0;
    wait_lna(1, "cfg_wait_ul2");
    tdd_in = 1;
    measure(40, -1, 0, t_pa, t_lna, t_sw);
    chk("cfg_next_sw_dl_at", t_sw, 23);
    chk("cfg_next_pa_on_at", t_pa, 26);

    // tdd_valid drop from DL_ON, then restart toward DL
    ul2dl_gap = 5;
    tick();
    tdd_valid = 0;
    tick();
    chk("inval_pa_en", pa_en, 0);
    chk("inval_lna_en", lna_en, 0);
    chk("inval_sw_dl", sw_dl, 0);
    tdd_valid = 1;
    measure(20, -1, 0, t_pa, t_lna, t_sw);
    chk("revalid_lna_stays_off", t_lna, -1);
    chk("revalid_sw_dl_at", t_sw, 7);
    chk("revalid_pa_on_at", t_pa, 10);

    // Reset from DL_ON, then restart toward DL
    i_rst = 1;
    tick();
    chk("rst_dl_pa_en", pa_en, 0);
    chk("rst_dl_sw_dl", sw_dl, 0);
    chk("rst_dl_abort_cnt", abort_cnt, 0);
    i_rst = 0;
    measure(20, -1, 0, t_pa, t_lna, t_sw);
    chk("rerst_lna_stays_off", t_lna, -1);
    chk("rerst_sw_dl_at", t_sw, 7);
    chk("rerst_pa_on_at", t_pa, 10);

    // Zero gaps, direction toggling every 2 cycles
    ul2dl_gap = 0; pa_on_dly = 0; dl2ul_gap = 0; lna_on_dly = 0;
    for (int i = 0; i < 500; i++) begin
      tdd_in = ~tdd_in;
      tick(); tick();
    end
    repeat (4) tick();
    chk("toggle_sat_abort_cnt", s_abort_cnt, 15);
    chk("toggle_abort_gt_15", (abort_cnt > 15) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
